pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage riscv32IMC pipeline.
- Detects load-use hazards at ID.
- Squashes wrong-path instructions when a branch or jump resolves taken in MEM.
- Freezes the front end while a multi-cycle divide/remainder operation occupies EX.
- Drives the load enables and synchronous-clear (flush) inputs of the PC, IF_ID, ID_EX and EX_MEM registers, plus the start/abort controls of the divider.

Parameters:
- REG_ADDR, 5, register address width.
- DIV_CYCLES, 32, total EX-occupancy cycles of a div/rem operation (legal range 2..255).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_id_rs1  in  REG_ADDR  rs1 field of IF_ID_Instruction.
- if_id_rs2  in  REG_ADDR  rs2 field of IF_ID_Instruction.
- if_id_uses_rs1  in  1  instruction in ID reads rs1.
- if_id_uses_rs2  in  1  instruction in ID reads rs2.
- id_ex_rd  in  REG_ADDR  rd field of ID_EX_Instruction.
- id_ex_mem_read  in  3  ID_EX mem_read code; nonzero means load.
- id_ex_is_div  in  1  ID_EX holds DIV/DIVU/REM/REMU.
- mem_redirect  in  1  branch_sel != 0 in MEM (taken branch or jump).
- pc_load  out  1  PC register load enable.
- if_id_load  out  1  IF_ID load enable.
- id_ex_load  out  1  ID_EX load enable.
- if_id_flush  out  1  clear IF_ID at next edge.
- id_ex_flush  out  1  load a bubble (all control zero) into ID_EX at next edge.
- ex_mem_flush  out  1  load a bubble into EX_MEM at next edge.
- div_start  out  1  one-cycle pulse that starts the divider.
- div_abort  out  1  one-cycle pulse that kills an in-flight divide.
- div_busy  out  1  FSM is in DIV_BUSY.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_load=0.

Behaviour:
- States: RUN, DIV_BUSY. Registers: state, div_cnt (8 bit), stall_cnt.
- Reset (asynchronous, while rst=1):
  - state=RUN, div_cnt=0, stall_cnt=0.
  - Outputs forced regardless of state: pc_load=0, if_id_load=0, id_ex_load=0, all three flushes=1, div_start=0, div_abort=0, div_busy=0.
  - First edge after release behaves as RUN.
- Load-use hazard, defined as lu = (id_ex_mem_read!=0) & (id_ex_rd!=0) & ((if_id_uses_rs1 & id_ex_rd==if_id_rs1) | (if_id_uses_rs2 & id_ex_rd==if_id_rs2)).
- Priority, highest first:
  1. mem_redirect
  2. DIV_BUSY hold
  3. div start
  4. lu
  5. normal flow
- RUN, mem_redirect=1:
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1; all loads=1.
  - div_start=0 even if id_ex_is_div=1; the div is younger than the branch and is killed.
  - Stay in RUN.
- RUN, id_ex_is_div=1, no redirect:
  - div_start=1; pc_load=0, if_id_load=0, id_ex_load=0; ex_mem_flush=1.
  - Next state DIV_BUSY, div_cnt=DIV_CYCLES-2.
- RUN, lu=1 (no redirect, no div):
  - pc_load=0, if_id_load=0, id_ex_load=1, id_ex_flush=1.
  - Lasts exactly one cycle; the load advances and the hazard clears.
  - MEM_WB forwarding supplies the data afterwards.
- RUN, otherwise: all loads=1, all flushes=0.
- DIV_BUSY, div_cnt!=0:
  - div_busy=1; pc_load=0, if_id_load=0, id_ex_load=0; ex_mem_flush=1.
  - div_cnt decrements each cycle.
- DIV_BUSY, div_cnt==0 (final cycle):
  - div_busy=1; all loads=1; all flushes=0; the div result enters EX_MEM.
  - Next state RUN.
  - Total front-end freeze = DIV_CYCLES-1 cycles; the div occupies EX for DIV_CYCLES cycles.
- DIV_BUSY, mem_redirect=1: does not occur, because MEM holds only bubbles. If it is asserted anyway, treat as RUN redirect:
  - Pulse div_abort=1, apply the full flush, go to RUN, div_cnt=0.
- lu is ignored in DIV_BUSY. It is re-evaluated on return to RUN.
- Back-to-back divs: the next div reaching ID_EX on the final-cycle edge triggers a fresh div_start in the following RUN cycle.
- stall_cnt: increments on each edge where pc_load=0 and rst=0; holds at 2^CNT_W-1 (no wrap).
- All outputs other than stall_cnt and div_busy are combinational from state, div_cnt and inputs. No combinational path runs from outputs to inputs.

Decomposition:
- Shared package/header: state encodings (RUN=1'b0, DIV_BUSY=1'b1), the ID_EX/EX_MEM bubble control value (all zero), and the mem_read "none" code 3'b000.
- Sub-module: sat_counter (width-parameterised saturating up-counter, async reset) used for stall_cnt. Everything else is a single module.

Test Plan:
- Reset mid-DIV_BUSY: assert rst at div_cnt=10 -> outputs immediately at reset values, state=RUN, stall_cnt=0; release -> normal flow with all loads=1.
- Load-use: ID_EX LW x5 (mem_read=3'b010), ID ADD x6,x5,x1 with uses_rs1=1 -> exactly one cycle pc_load=0, if_id_load=0, id_ex_flush=1, then normal flow. Same case with rd=x0 -> no stall.
- Divide, DIV_CYCLES=32: id_ex_is_div=1 -> div_start pulses for 1 cycle, front end frozen for 31 cycles, ex_mem_flush=1 for 31 cycles, loads=1 on the 32nd cycle, stall_cnt +31.
- Redirect beats div and lu: mem_redirect=1 with id_ex_is_div=1 and lu=1 simultaneously -> all three flushes=1, loads=1, div_start=0, no stall.
- Forced redirect in DIV_BUSY -> div_abort=1 for one cycle, full flush, RUN next cycle.
- Saturation, CNT_W=4: hold 20 stall cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_BUSY = 1'b1
  } state_e;

  localparam logic [2:0] MEM_READ_NONE = 3'b000;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic div_start;
    logic div_abort;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = ctrl_t'(8'h00);
  localparam ctrl_t CTRL_RESET  = ctrl_t'(8'b000_111_00);
  localparam ctrl_t CTRL_NORMAL = ctrl_t'(8'b111_000_00);
  localparam ctrl_t CTRL_SQUASH = ctrl_t'(8'b111_111_00);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(8'b000_001_00);
  localparam ctrl_t CTRL_LU     = ctrl_t'(8'b001_010_00);

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Width-parameterised saturating up-counter with asynchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already at the top value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use stalls, taken-branch squash in MEM, and
// front-end freeze while a multi-cycle divide occupies EX.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR   = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ADDR-1:0] if_id_rs1,
  input  logic [REG_ADDR-1:0] if_id_rs2,
  input  logic                if_id_uses_rs1,
  input  logic                if_id_uses_rs2,
  input  logic [REG_ADDR-1:0] id_ex_rd,
  input  logic [2:0]          id_ex_mem_read,
  input  logic                id_ex_is_div,
  input  logic                mem_redirect,
  output logic                pc_load,
  output logic                if_id_load,
  output logic                id_ex_load,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                ex_mem_flush,
  output logic                div_start,
  output logic                div_abort,
  output logic                div_busy,
  output logic [CNT_W-1:0]    stall_cnt
);

  state_e     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  ctrl_t      ctrl_s;
  ctrl_t      out_s;
  logic       lu_s;

  assign lu_s = (id_ex_mem_read != MEM_READ_NONE) && (id_ex_rd != '0) &&
                ((if_id_uses_rs1 && (id_ex_rd == if_id_rs1)) ||
                 (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

  // Next state and control decode; redirect outranks everything because
  // anything younger than a taken branch is wrong-path.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    ctrl_s    = BUBBLE_CTRL;
    case (state_q)
      RUN: begin
        if (mem_redirect) begin
          ctrl_s    = CTRL_SQUASH;
          div_cnt_d = 8'd0;
        end else if (id_ex_is_div) begin
          ctrl_s           = CTRL_FREEZE;
          ctrl_s.div_start = 1'b1;
          state_d          = DIV_BUSY;
          div_cnt_d        = 8'(DIV_CYCLES - 2);
        end else if (lu_s) begin
          ctrl_s = CTRL_LU;
        end else begin
          ctrl_s = CTRL_NORMAL;
        end
      end
      DIV_BUSY: begin
        if (mem_redirect) begin
          ctrl_s           = CTRL_SQUASH;
          ctrl_s.div_abort = 1'b1;
          state_d          = RUN;
          div_cnt_d        = 8'd0;
        end else if (div_cnt_q != 8'd0) begin
          ctrl_s    = CTRL_FREEZE;
          div_cnt_d = div_cnt_q - 8'd1;
        end else begin
          ctrl_s  = CTRL_NORMAL;
          state_d = RUN;
        end
      end
      default: begin
        ctrl_s    = CTRL_RESET;
        state_d   = RUN;
        div_cnt_d = 8'd0;
      end
    endcase
  end

  // Reset overrides the decoded controls immediately, not at the next edge.
  always_comb begin
    if (rst) begin
      out_s = CTRL_RESET;
    end else begin
      out_s = ctrl_s;
    end
  end

  // State and divide countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      div_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign pc_load      = out_s.pc_load;
  assign if_id_load   = out_s.if_id_load;
  assign id_ex_load   = out_s.id_ex_load;
  assign if_id_flush  = out_s.if_id_flush;
  assign id_ex_flush  = out_s.id_ex_flush;
  assign ex_mem_flush = out_s.ex_mem_flush;
  assign div_start    = out_s.div_start;
  assign div_abort    = out_s.div_abort;
  assign div_busy     = (state_q == DIV_BUSY) && !rst;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (!out_s.pc_load),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the hazard controller.
module tb_pipeline_hazard_ctrl;

  localparam int DIV_CYCLES = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, ex_rd;
  logic       u1, u2, is_div, redirect;
  logic [2:0] mem_read;

  logic pc_load, if_id_load, id_ex_load, if_id_flush, id_ex_flush, ex_mem_flush;
  logic div_start, div_abort, div_busy;
  logic [15:0] stall_cnt;
  logic p4, il4, el4, if4, ef4, mf4, ds4, da4, db4;
  logic [3:0] stall_cnt4;

  logic [8:0] act, act4;
  assign act  = {pc_load, if_id_load, id_ex_load, if_id_flush, id_ex_flush,
                 ex_mem_flush, div_start, div_abort, div_busy};
  assign act4 = {p4, il4, el4, if4, ef4, mf4, ds4, da4, db4};

  int checks = 0;
  int failures = 0;

  // model: busy flag, cycles left in the divide (including the final one), counters
  bit m_busy;
  int m_left;
  int m_cnt;
  int m_cnt4;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs1(u1), .if_id_uses_rs2(u2), .id_ex_rd(ex_rd),
    .id_ex_mem_read(mem_read), .id_ex_is_div(is_div), .mem_redirect(redirect),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .div_start(div_start), .div_abort(div_abort), .div_busy(div_busy),
    .stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2),
    .if_id_uses_rs1(u1), .if_id_uses_rs2(u2), .id_ex_rd(ex_rd),
    .id_ex_mem_read(mem_read), .id_ex_is_div(is_div), .mem_redirect(redirect),
    .pc_load(p4), .if_id_load(il4), .id_ex_load(el4),
    .if_id_flush(if4), .id_ex_flush(ef4), .ex_mem_flush(mf4),
    .div_start(ds4), .div_abort(da4), .div_busy(db4),
    .stall_cnt(stall_cnt4)
  );

  // Expected output vector from the spec rules and the model's state.
  function automatic logic [8:0] model_exp();
    bit lu;
    lu = (mem_read != 3'd0) && (ex_rd != 5'd0) &&
         ((u1 && ex_rd == rs1) || (u2 && ex_rd == rs2));
    if (rst) return 9'b000_111_000;
    if (!m_busy) begin
      if (redirect) return 9'b111_111_000;
      if (is_div)   return 9'b000_001_100;
      if (lu)       return 9'b001_010_000;
      return 9'b111_000_000;
    end
    if (redirect)    return 9'b111_111_011;
    if (m_left > 1)  return 9'b000_001_001;
    return 9'b111_000_001;
  endfunction

  task automatic tick();
    logic [8:0] e;
    e = model_exp();
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_left = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (!e[8]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (!m_busy) begin
        if (!redirect && is_div) begin
          m_busy = 1'b1;
          m_left = DIV_CYCLES - 1;
        end
      end else if (redirect || m_left <= 1) begin
        m_busy = 1'b0;
      end else begin
        m_left--;
      end
    end
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd1; rs2 = 5'd2; ex_rd = 5'd3; u1 = 1'b0; u2 = 1'b0;
    mem_read = 3'd0; is_div = 1'b0; redirect = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    checks++;
    if (act !== 9'b000_111_000 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset: got ctrl=%b cnt=%0d want ctrl=000111000 cnt=0", act, stall_cnt);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (act !== 9'b111_000_000) begin
      failures++;
      $display("FAIL reset_release: got %b want 111000000", act);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_rd = 5'd5; mem_read = 3'b010; rs1 = 5'd5; rs2 = 5'd1; u1 = 1'b1; u2 = 1'b1;
    #1;
    checks++;
    if (act !== 9'b001_010_000) begin
      failures++;
      $display("FAIL load_use_stall: got %b want 001010000", act);
    end
    tick();
    ex_rd = 5'd6; mem_read = 3'd0; rs1 = 5'd6;
    #1;
    checks++;
    if (act !== 9'b111_000_000 || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_after: got %b cnt=%0d want 111000000 cnt=1", act, stall_cnt);
    end
    ex_rd = 5'd0; mem_read = 3'b010; rs1 = 5'd0;
    #1;
    checks++;
    if (act !== 9'b111_000_000) begin
      failures++;
      $display("FAIL load_use_x0: got %b want 111000000", act);
    end
    ex_rd = 5'd9; rs1 = 5'd4; rs2 = 5'd9; u2 = 1'b1;
    #1;
    checks++;
    if (act !== 9'b001_010_000) begin
      failures++;
      $display("FAIL load_use_rs2: got %b want 001010000", act);
    end
    u2 = 1'b0;
    #1;
    checks++;
    if (act !== 9'b111_000_000) begin
      failures++;
      $display("FAIL load_use_unused_rs2: got %b want 111000000", act);
    end
    tick();
  endtask

  task automatic test_divide();
    int frozen, starts, base;
    do_reset();
    base = stall_cnt;
    frozen = 0; starts = 0;
    is_div = 1'b1;
    for (int i = 0; i < DIV_CYCLES; i++) begin
      #1;
      checks++;
      if (act !== model_exp()) begin
        failures++;
        $display("FAIL divide_cycle%0d: got %b want %b", i, act, model_exp());
      end
      if (!pc_load) frozen++;
      if (div_start) starts++;
      if (i == DIV_CYCLES - 1) begin
        checks++;
        if (act !== 9'b111_000_001) begin
          failures++;
          $display("FAIL divide_final: got %b want 111000001", act);
        end
      end
      tick();
      is_div = 1'b0;
    end
    checks++;
    if (frozen != DIV_CYCLES - 1 || starts != 1 || int'(stall_cnt) - base != DIV_CYCLES - 1) begin
      failures++;
      $display("FAIL divide_totals: frozen=%0d starts=%0d dcnt=%0d want %0d 1 %0d",
               frozen, starts, int'(stall_cnt) - base, DIV_CYCLES - 1, DIV_CYCLES - 1);
    end
    #1;
    checks++;
    if (act !== 9'b111_000_000) begin
      failures++;
      $display("FAIL divide_return: got %b want 111000000", act);
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    redirect = 1'b1; is_div = 1'b1;
    ex_rd = 5'd7; mem_read = 3'b010; rs1 = 5'd7; u1 = 1'b1;
    #1;
    checks++;
    if (act !== 9'b111_111_000) begin
      failures++;
      $display("FAIL redirect_priority: got %b want 111111000", act);
    end
    tick();
    idle();
    #1;
    checks++;
    if (act !== 9'b111_000_000 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL redirect_after: got %b cnt=%0d want 111000000 cnt=0", act, stall_cnt);
    end
  endtask

  task automatic test_div_abort();
    do_reset();
    is_div = 1'b1;
    tick();
    is_div = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    redirect = 1'b1;
    #1;
    checks++;
    if (act !== 9'b111_111_011) begin
      failures++;
      $display("FAIL div_abort: got %b want 111111011", act);
    end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (act !== 9'b111_000_000 || stall_cnt !== 16'd6) begin
      failures++;
      $display("FAIL div_abort_after: got %b cnt=%0d want 111000000 cnt=6", act, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    is_div = 1'b1;
    tick();
    is_div = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #1;
    checks++;
    if (act !== 9'b000_001_001) begin
      failures++;
      $display("FAIL mid_div_busy: got %b want 000001001", act);
    end
    rst = 1'b1;
    m_busy = 1'b0; m_cnt = 0; m_cnt4 = 0;
    #1;
    checks++;
    if (act !== 9'b000_111_000 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mid_div_reset: got %b cnt=%0d want 000111000 cnt=0", act, stall_cnt);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (act !== 9'b111_000_000) begin
      failures++;
      $display("FAIL mid_div_release: got %b want 111000000", act);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_rd = 5'd5; mem_read = 3'b001; rs1 = 5'd5; u1 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (stall_cnt4 !== 4'((i > 15) ? 15 : i)) begin
        failures++;
        $display("FAIL saturate_%0d: got %0d want %0d", i, stall_cnt4, (i > 15) ? 15 : i);
      end
    end
    checks++;
    if (stall_cnt !== 16'd20) begin
      failures++;
      $display("FAIL saturate_wide: got %0d want 20", stall_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      u1 = 1'($urandom_range(0, 1));
      u2 = 1'($urandom_range(0, 1));
      mem_read = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      is_div = ($urandom_range(0, 19) == 0);
      redirect = ($urandom_range(0, 24) == 0);
      #1;
      checks++;
      if (act !== model_exp() || act4 !== model_exp()) begin
        failures++;
        $display("FAIL random_%0d: got %b/%b want %b", i, act, act4, model_exp());
      end
      tick();
      checks++;
      if (stall_cnt !== 16'(m_cnt) || stall_cnt4 !== 4'(m_cnt4)) begin
        failures++;
        $display("FAIL random_cnt_%0d: got %0d/%0d want %0d/%0d",
                 i, stall_cnt, stall_cnt4, m_cnt, m_cnt4);
      end
    end
    idle();
  endtask

  initial begin
    m_busy = 1'b0; m_left = 0; m_cnt = 0; m_cnt4 = 0;
    test_reset();
    test_load_use();
    test_divide();
    test_redirect_priority();
    test_div_abort();
    test_reset_mid_div();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
